// File: rtl/kbd_inject_if.sv
// Key-code offer channel into the injection queue: the producer offers a code
// with in_valid, and the arbiter accepts it in any cycle where in_ready is high.
interface kbd_inject_if;
  logic [15:0] in_code;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_code, output in_valid, input in_ready);
  modport slave  (input in_code, input in_valid, output in_ready);
endinterface

// File: rtl/kbd_inject_arbiter.sv
// Keyboard injection arbiter. Queued key codes are "pressed" onto the ULA
// keyboard matrix one at a time. Each key is held for PRESS_TICKS cycles and
// is followed by a RELEASE_TICKS all-released gap. A key starts only after
// the live keyboard has been idle for HOLDOFF_TICKS consecutive cycles. The
// injected keys are merged (ANDed) with the live matrix, so a key that is
// held on the real keyboard still reaches the ULA during an injection.
module kbd_inject_arbiter #(
  parameter int PRESS_TICKS   = 2700000,
  parameter int RELEASE_TICKS = 2700000,
  parameter int HOLDOFF_TICKS = 270000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  kbd_inject_if.slave                   bus,
  input  logic                          abort,
  input  logic [39:0]                   live_matrix,
  input  logic [7:0]                    ula_addr_hi,
  output logic [4:0]                    ula_kbd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int TICK_MAX = (PRESS_TICKS > RELEASE_TICKS) ? PRESS_TICKS : RELEASE_TICKS;
  localparam int TIMER_W  = (TICK_MAX > 1) ? $clog2(TICK_MAX + 1) : 1;
  localparam int QUIET_W  = (HOLDOFF_TICKS > 1) ? $clog2(HOLDOFF_TICKS + 1) : 1;

  localparam logic [CNT_W-1:0]   DEPTH_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [TIMER_W-1:0] PRESS_LAST   = TIMER_W'(PRESS_TICKS - 1);
  localparam logic [TIMER_W-1:0] RELEASE_LAST = TIMER_W'(RELEASE_TICKS - 1);
  localparam logic [QUIET_W-1:0] HOLDOFF_Q    = QUIET_W'(HOLDOFF_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_RELEASE
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [QUIET_W-1:0] quiet;
  logic [39:0]        inject;
  logic [39:0]        merged;

  logic [15:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Turn a key code into a full 8x5 active-low matrix. The shift keys live at
  // fixed positions: CAPS SHIFT is row 0 column 0, SYMBOL SHIFT is row 7
  // column 1. A row number above 7 matches no row, so only the shifts apply.
  function automatic logic [39:0] decode_key(input logic [15:0] code);
    logic [39:0] m;
    m = '1;
    for (int r = 0; r < 8; r++) begin
      if (code[15:8] == 8'(r)) m[5*r +: 5] = code[4:0];
    end
    if (code[6]) m[0]  = 1'b0;
    if (code[5]) m[36] = 1'b0;
    return m;
  endfunction

  assign full         = (fifo_count == DEPTH_CNT);
  assign empty        = (fifo_count == '0);
  assign bus.in_ready = !full && !abort && !reset;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == S_IDLE) && !empty && (quiet == HOLDOFF_Q) && !abort;
  assign busy         = !reset && ((state != S_IDLE) || !empty);
  assign merged       = live_matrix & inject;

  // Queue storage: written on an accepted push.
  // NOTE: the storage array has no reset; pointers and fifo_count alone decide
  // which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_code;
  end

  // Queue pointers and occupancy; abort and reset both empty the queue.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Count consecutive cycles with no live key down, saturating at the holdoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      quiet <= '0;
    end else if (&live_matrix) begin
      if (quiet != HOLDOFF_Q) quiet <= quiet + QUIET_W'(1);
    end else begin
      quiet <= '0;
    end
  end

  // Press/release sequencer; owns the registered inject matrix.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state  <= S_IDLE;
      inject <= '1;
      timer  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state  <= S_PRESS;
            inject <= decode_key(mem[rd_ptr]);
            timer  <= '0;
          end
        end
        S_PRESS: begin
          if (timer == PRESS_LAST) begin
            state  <= S_RELEASE;
            inject <= '1;
            timer  <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        S_RELEASE: begin
          if (timer == RELEASE_LAST) begin
            state <= S_IDLE;
            timer <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          inject <= '1;
          timer  <= '0;
        end
      endcase
    end
  end

  // ULA column read: AND together every merged row whose address line is low.
  // NOTE: ula_kbd is given its value before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ula_kbd = '1;
    for (int r = 0; r < 8; r++) begin
      if (!ula_addr_hi[r]) ula_kbd = ula_kbd & merged[5*r +: 5];
    end
  end

endmodule

// File: tb/tb_kbd_inject_arbiter.sv
// Self-checking bench for kbd_inject_arbiter. A timeline model keeps the
// accepted codes in a queue and records the cycle of each pop; from that it
// derives which cycles show the key, which cycles are busy, and when the next
// pop is allowed. A monitor compares the DUT against it every cycle by
// scanning each ULA row select.
module tb_kbd_inject_arbiter;

  localparam int P = 4;
  localparam int R = 3;
  localparam int H = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        abort;
  logic [39:0] live_matrix;
  logic [7:0]  ula_addr_hi;
  logic [4:0]  ula_kbd;
  logic        busy;
  logic [2:0]  fifo_count;

  kbd_inject_if bus ();

  kbd_inject_arbiter #(
    .PRESS_TICKS   (P),
    .RELEASE_TICKS (R),
    .HOLDOFF_TICKS (H),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .abort       (abort),
    .live_matrix (live_matrix),
    .ula_addr_hi (ula_addr_hi),
    .ula_kbd     (ula_kbd),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #20 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] exp_q[$];          // accepted codes not yet injected
  int          cyc      = 0;      // index of the cycle now in progress
  int          quiet    = 0;      // consecutive live-idle cycles, capped at H
  int          last_pop = -1000;  // cycle of the most recent pop
  logic [39:0] key_m    = '1;     // matrix of the most recently popped key

  function automatic logic [39:0] model_key(input logic [15:0] code);
    logic [39:0] m;
    logic [4:0]  v;
    int          row;
    row = int'(code[15:8]);
    for (int r = 0; r < 8; r++) begin
      v = 5'b11111;
      if (row == r) v = code[4:0];
      if (r == 0 && code[6]) v = v & 5'b11110;
      if (r == 7 && code[5]) v = v & 5'b11101;
      m[5*r +: 5] = v;
    end
    return m;
  endfunction

  // Key shown on cycles last_pop+1 .. last_pop+P.
  function automatic bit visible(input int c);
    return (c > last_pop) && (c <= last_pop + P);
  endfunction

  // Not idle on cycles last_pop+1 .. last_pop+P+R.
  function automatic bit engaged(input int c);
    return (c > last_pop) && (c <= last_pop + P + R);
  endfunction

  always @(posedge clk) begin
    bit acc;
    bit pk;
    if (reset) begin
      exp_q.delete();
      quiet    = 0;
      last_pop = -1000;
    end else begin
      acc = bus.in_valid && (exp_q.size() < D) && !abort;
      pk  = !engaged(cyc) && (exp_q.size() > 0) && (quiet == H) && !abort;
      if (abort) begin
        exp_q.delete();
        last_pop = -1000;
      end else begin
        if (pk) begin
          key_m    = model_key(exp_q.pop_front());
          last_pop = cyc;
        end
        if (acc) exp_q.push_back(bus.in_code);
      end
      quiet = (live_matrix == '1) ? ((quiet < H) ? quiet + 1 : H) : 0;
    end
    cyc++;
  end

  // ---------------- monitor ----------------
  bit mon_en = 1'b0;

  always @(negedge clk) begin
    logic [39:0] exp_mrg;
    logic [39:0] got_mrg;
    logic [4:0]  exp_sel;
    logic [7:0]  a;
    if (mon_en) begin
      exp_mrg = live_matrix & (visible(cyc) ? key_m : 40'hFF_FFFF_FFFF);
      for (int r = 0; r < 8; r++) begin
        ula_addr_hi = ~(8'(1) << r);
        #1;
        got_mrg[5*r +: 5] = ula_kbd;
      end
      check("row_scan", cyc, 64'(got_mrg), 64'(exp_mrg));

      ula_addr_hi = 8'h00;
      #1;
      exp_sel = 5'b11111;
      for (int r = 0; r < 8; r++) exp_sel = exp_sel & exp_mrg[5*r +: 5];
      check("all_rows", cyc, 64'(ula_kbd), 64'(exp_sel));

      ula_addr_hi = 8'hFF;
      #1;
      check("no_row", cyc, 64'(ula_kbd), 64'(5'b11111));

      a = 8'($urandom);
      ula_addr_hi = a;
      #1;
      exp_sel = 5'b11111;
      for (int r = 0; r < 8; r++) if (!a[r]) exp_sel = exp_sel & exp_mrg[5*r +: 5];
      check("rand_sel", cyc, 64'(ula_kbd), 64'(exp_sel));

      check("busy", cyc, 64'(busy), 64'(!reset && (engaged(cyc) || exp_q.size() > 0)));
      check("fifo_count", cyc, 64'(fifo_count), 64'(exp_q.size()));
      check("in_ready", cyc, 64'(bus.in_ready), 64'(!reset && !abort && exp_q.size() < D));
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [39:0] IDLE_LIVE = 40'hFF_FFFF_FFFF;

  task automatic step(input bit v, input logic [15:0] c, input bit ab, input logic [39:0] lv);
    bus.in_valid = v;
    bus.in_code  = c;
    abort        = ab;
    live_matrix  = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0000, 1'b0, IDLE_LIVE);
  endtask

  initial begin
    logic [39:0] lv;
    reset        = 1'b1;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_code  = '0;
    live_matrix  = IDLE_LIVE;
    ula_addr_hi  = 8'hFF;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle(2);
    reset = 1'b0;

    // Single key on row 0, then drain.
    step(1'b1, 16'h0017, 1'b0, IDLE_LIVE);
    idle(15);

    // Shifted keys: row 7 with CAPS, then row 0 cols open with both shifts.
    step(1'b1, 16'h0741, 1'b0, IDLE_LIVE);
    step(1'b1, 16'h007F, 1'b0, IDLE_LIVE);
    idle(25);

    // Fill the queue while a live key is held; fifth offer must be refused.
    lv = ~(40'(1) << 15);
    step(1'b1, 16'h0017, 1'b0, lv);
    step(1'b1, 16'h011E, 1'b0, lv);
    step(1'b1, 16'h020F, 1'b0, lv);
    step(1'b1, 16'h0340, 1'b0, lv);
    step(1'b1, 16'h041B, 1'b0, lv);
    repeat (3) step(1'b0, 16'h0000, 1'b0, lv);
    idle(45);

    // Live key on the same row as the injected one, held through the press.
    step(1'b1, 16'h011D, 1'b0, IDLE_LIVE);
    step(1'b0, 16'h0000, 1'b0, IDLE_LIVE);
    repeat (7) step(1'b0, 16'h0000, 1'b0, ~(40'(1) << 5));
    idle(12);

    // Abort mid-press with three codes queued; the push in that cycle is lost.
    step(1'b1, 16'h0017, 1'b0, IDLE_LIVE);
    step(1'b1, 16'h0117, 1'b0, IDLE_LIVE);
    step(1'b1, 16'h0217, 1'b0, IDLE_LIVE);
    step(1'b1, 16'h0317, 1'b0, IDLE_LIVE);
    step(1'b1, 16'h0417, 1'b1, IDLE_LIVE);
    idle(10);

    // Reset during RELEASE, then a clean restart.
    step(1'b1, 16'h0017, 1'b0, IDLE_LIVE);
    idle(6);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    step(1'b1, 16'h0217, 1'b0, IDLE_LIVE);
    idle(15);

    // Randomized traffic: sparse live keys, occasional abort and reset.
    for (int i = 0; i < 1500; i++) begin
      lv    = ($urandom_range(0, 7) == 0) ? ~(40'(1) << $urandom_range(0, 39)) : IDLE_LIVE;
      reset = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 2) == 0,
           {8'($urandom_range(0, 9)), 8'($urandom)},
           $urandom_range(0, 99) == 0,
           lv);
    end
    reset = 1'b0;
    idle(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
